// File: rtl/timer_cfg_sequencer.sv
// Timer configuration sequencer: turns start/stop commands into timer register
// writes, and services timer interrupts by reading and clearing the status register.
module timer_cfg_sequencer #(
  parameter logic [7:0] TDR_ADDR = 8'h00,
  parameter logic [7:0] TCR_ADDR = 8'h01,
  parameter logic [7:0] TSR_ADDR = 8'h02,
  parameter logic [7:0] TIE_ADDR = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_stop,
  input  logic [7:0] cmd_load_val,
  input  logic       cmd_down,
  input  logic [1:0] cmd_cks,
  input  logic       cmd_ovf_ie,
  input  logic       cmd_udf_ie,
  output logic       m_sel,
  output logic       m_write,
  output logic [7:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic [7:0] m_rdata,
  input  logic       m_ready,
  input  logic       timer_irq,
  output logic       evt_valid,
  output logic       evt_ovf,
  output logic       evt_udf,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, WR_TDR, WR_TCR_LD, WR_TCR_RUN, WR_TIE, WR_STOP, RD_TSR, WR_TSR, EVT
  } state_t;

  state_t     r_state;
  logic       r_m_sel, r_m_write;
  logic [7:0] r_m_addr, r_m_wdata;
  logic       r_evt_valid, r_evt_ovf, r_evt_udf;
  logic       r_down, r_ovf_ie, r_udf_ie;
  logic [1:0] r_cks;
  logic [1:0] r_sts;   // {udf, ovf}

  // Only the two flag bits of the status register are meaningful.
  logic w_rdata_unused;
  assign w_rdata_unused = ^m_rdata[7:2];

  assign cmd_ready = !rst && (r_state == IDLE) && !timer_irq;
  assign busy      = (r_state != IDLE);
  assign m_sel     = r_m_sel;
  assign m_write   = r_m_write;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign evt_valid = r_evt_valid;
  assign evt_ovf   = r_evt_ovf;
  assign evt_udf   = r_evt_udf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_m_sel     <= 1'b0;
      r_m_write   <= 1'b0;
      r_m_addr    <= 8'h00;
      r_m_wdata   <= 8'h00;
      r_evt_valid <= 1'b0;
      r_evt_ovf   <= 1'b0;
      r_evt_udf   <= 1'b0;
      r_down      <= 1'b0;
      r_cks       <= 2'b00;
      r_ovf_ie    <= 1'b0;
      r_udf_ie    <= 1'b0;
      r_sts       <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          r_evt_valid <= 1'b0;
          r_evt_ovf   <= 1'b0;
          r_evt_udf   <= 1'b0;
          if (timer_irq) begin
            r_state   <= RD_TSR;
            r_m_sel   <= 1'b1;
            r_m_write <= 1'b0;
            r_m_addr  <= TSR_ADDR;
            r_m_wdata <= 8'h00;
          end else if (cmd_valid) begin
            r_down    <= cmd_down;
            r_cks     <= cmd_cks;
            r_ovf_ie  <= cmd_ovf_ie;
            r_udf_ie  <= cmd_udf_ie;
            r_m_sel   <= 1'b1;
            r_m_write <= 1'b1;
            if (cmd_stop) begin
              r_state   <= WR_STOP;
              r_m_addr  <= TCR_ADDR;
              r_m_wdata <= 8'h00;
            end else begin
              r_state   <= WR_TDR;
              r_m_addr  <= TDR_ADDR;
              r_m_wdata <= cmd_load_val;
            end
          end
        end
        WR_TDR: if (m_ready) begin
          r_state   <= WR_TCR_LD;
          r_m_addr  <= TCR_ADDR;
          r_m_wdata <= {1'b1, 1'b0, r_down, 1'b0, 2'b00, r_cks};
        end
        WR_TCR_LD: if (m_ready) begin
          r_state   <= WR_TCR_RUN;
          r_m_addr  <= TCR_ADDR;
          r_m_wdata <= {1'b0, 1'b0, r_down, 1'b1, 2'b00, r_cks};
        end
        WR_TCR_RUN: if (m_ready) begin
          r_state   <= WR_TIE;
          r_m_addr  <= TIE_ADDR;
          r_m_wdata <= {6'b000000, r_udf_ie, r_ovf_ie};
        end
        WR_TIE, WR_STOP: if (m_ready) begin
          r_state   <= IDLE;
          r_m_sel   <= 1'b0;
          r_m_write <= 1'b0;
        end
        RD_TSR: if (m_ready) begin
          r_sts <= m_rdata[1:0];
          if (m_rdata[1:0] == 2'b00) begin
            // Nothing flagged: drop the interrupt without an event.
            r_state <= IDLE;
            r_m_sel <= 1'b0;
          end else begin
            r_state   <= WR_TSR;
            r_m_write <= 1'b1;
            r_m_addr  <= TSR_ADDR;
            r_m_wdata <= {6'b000000, m_rdata[1:0]};
          end
        end
        WR_TSR: if (m_ready) begin
          r_state     <= EVT;
          r_m_sel     <= 1'b0;
          r_m_write   <= 1'b0;
          r_evt_valid <= 1'b1;
          r_evt_ovf   <= r_sts[0];
          r_evt_udf   <= r_sts[1];
        end
        EVT: begin
          r_state     <= IDLE;
          r_evt_valid <= 1'b0;
          r_evt_ovf   <= 1'b0;
          r_evt_udf   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_m_sel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
// Directed bench for timer_cfg_sequencer: command sequences, interrupt service,
// wait states and asynchronous reset, with hand-computed bus traces.
module tb_timer_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_stop = 1'b0;
  logic [7:0] cmd_load_val = 8'h00;
  logic       cmd_down = 1'b0;
  logic [1:0] cmd_cks = 2'b00;
  logic       cmd_ovf_ie = 1'b0, cmd_udf_ie = 1'b0;
  logic       m_sel, m_write;
  logic [7:0] m_addr, m_wdata;
  logic [7:0] m_rdata = 8'h00;
  logic       m_ready = 1'b1;
  logic       timer_irq = 1'b0;
  logic       evt_valid, evt_ovf, evt_udf, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int evt_cnt = 0;
  logic [16:0] log_q[$];   // {write, addr, data}

  timer_cfg_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_stop(cmd_stop),
    .cmd_load_val(cmd_load_val), .cmd_down(cmd_down), .cmd_cks(cmd_cks),
    .cmd_ovf_ie(cmd_ovf_ie), .cmd_udf_ie(cmd_udf_ie),
    .m_sel(m_sel), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .timer_irq(timer_irq),
    .evt_valid(evt_valid), .evt_ovf(evt_ovf), .evt_udf(evt_udf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Completed bus transactions and event pulses, observed mid-cycle.
  always @(negedge clk) begin
    if (!rst && m_sel && m_ready)
      log_q.push_back({m_write, m_addr, m_write ? m_wdata : m_rdata});
    if (evt_valid) evt_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < log_q.size()) return {15'd0, log_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_sel",   m_sel, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_evt",   evt_valid, 0);
    chk("rst_addr",  m_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rel_ready", cmd_ready, 1);

    // Start command, m_ready tied high
    tick();
    log_q.delete();
    cmd_valid = 1; cmd_stop = 0; cmd_load_val = 8'hF0; cmd_down = 0; cmd_cks = 2;
    cmd_ovf_ie = 1; cmd_udf_ie = 0;
    tick();
    chk("st_sel",   m_sel, 1);
    chk("st_addr0", m_addr, 8'h00);
    chk("st_busy",  busy, 1);
    chk("st_rdy0",  cmd_ready, 0);
    cmd_valid = 0; cmd_load_val = 8'h55; cmd_down = 1; cmd_cks = 0;
    cmd_ovf_ie = 0; cmd_udf_ie = 1;
    repeat (3) tick();
    chk("st_rdy4",  cmd_ready, 0);
    chk("st_tie",   m_addr, 8'h03);
    tick();
    chk("st_rdy5",  cmd_ready, 1);
    chk("st_idle",  m_sel, 0);
    chk("st_n",     log_q.size(), 4);
    chk("st_w0",    log_at(0), {15'd0, 1'b1, 8'h00, 8'hF0});
    chk("st_w1",    log_at(1), {15'd0, 1'b1, 8'h01, 8'h82});
    chk("st_w2",    log_at(2), {15'd0, 1'b1, 8'h01, 8'h12});
    chk("st_w3",    log_at(3), {15'd0, 1'b1, 8'h03, 8'h01});

    // Interrupt service, overflow only
    log_q.delete(); evt_cnt = 0;
    m_rdata = 8'h01; timer_irq = 1;
    #1 chk("irq_rdy", cmd_ready, 0);
    tick();
    chk("irq_rd",   {m_sel, m_write, m_addr}, {1'b1, 1'b0, 8'h02});
    tick();
    chk("irq_wr",   {m_write, m_addr, m_wdata}, {1'b1, 8'h02, 8'h01});
    timer_irq = 0;
    tick();
    chk("irq_evt",  {evt_valid, evt_ovf, evt_udf, m_sel}, 4'b1100);
    tick();
    chk("irq_post", {evt_valid, evt_ovf, evt_udf, busy}, 4'b0000);
    chk("irq_n",    log_q.size(), 2);
    chk("irq_l0",   log_at(0), {15'd0, 1'b0, 8'h02, 8'h01});
    chk("irq_l1",   log_at(1), {15'd0, 1'b1, 8'h02, 8'h01});
    chk("irq_cnt",  evt_cnt, 1);

    // Overflow and underflow together
    log_q.delete();
    m_rdata = 8'h03; timer_irq = 1;
    tick(); tick();
    timer_irq = 0;
    chk("both_wr",  m_wdata, 8'h03);
    tick();
    chk("both_evt", {evt_valid, evt_ovf, evt_udf}, 3'b111);
    tick();
    chk("both_n",   log_q.size(), 2);

    // Spurious interrupt
    log_q.delete(); evt_cnt = 0;
    m_rdata = 8'h00; timer_irq = 1;
    tick();
    timer_irq = 0;
    tick();
    chk("sp_idle",  {busy, m_sel}, 2'b00);
    repeat (3) tick();
    chk("sp_n",     log_q.size(), 1);
    chk("sp_l0",    log_at(0), {15'd0, 1'b0, 8'h02, 8'h00});
    chk("sp_evt",   evt_cnt, 0);

    // Command and interrupt arriving together: interrupt wins
    log_q.delete();
    m_rdata = 8'h01; cmd_valid = 1; cmd_stop = 1; timer_irq = 1;
    #1 chk("sim_rdy", cmd_ready, 0);
    tick(); tick();
    timer_irq = 0;
    begin
      int k = 0;
      while (!cmd_ready && k < 20) begin tick(); k++; end
      chk("sim_wait", k < 20, 1);
    end
    tick();
    cmd_valid = 0; cmd_stop = 0;
    chk("stop_bus", {m_sel, m_write, m_addr, m_wdata}, {1'b1, 1'b1, 8'h01, 8'h00});
    tick();
    chk("stop_idle", busy, 0);
    chk("sim_n",    log_q.size(), 3);
    chk("sim_l0",   log_at(0), {15'd0, 1'b0, 8'h02, 8'h01});
    chk("sim_l1",   log_at(1), {15'd0, 1'b1, 8'h02, 8'h01});
    chk("sim_l2",   log_at(2), {15'd0, 1'b1, 8'h01, 8'h00});

    // Wait states during the TCR load write
    log_q.delete();
    cmd_valid = 1; cmd_load_val = 8'h33; cmd_down = 0; cmd_cks = 2;
    cmd_ovf_ie = 0; cmd_udf_ie = 0;
    tick();
    cmd_valid = 0;
    tick();
    m_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_hold", {m_sel, m_addr, m_wdata}, {1'b1, 8'h01, 8'h82});
    end
    m_ready = 1;
    tick();
    chk("ws_run",   {m_addr, m_wdata}, {8'h01, 8'h12});
    tick(); tick();
    chk("ws_idle",  busy, 0);
    chk("ws_n",     log_q.size(), 4);
    chk("ws_l1",    log_at(1), {15'd0, 1'b1, 8'h01, 8'h82});
    chk("ws_l3",    log_at(3), {15'd0, 1'b1, 8'h03, 8'h00});

    // Asynchronous reset in WR_TCR_RUN
    log_q.delete();
    cmd_valid = 1; cmd_load_val = 8'h77; cmd_down = 1; cmd_cks = 1;
    cmd_ovf_ie = 1; cmd_udf_ie = 1;
    tick();
    cmd_valid = 0;
    tick(); tick();
    chk("rm_run",   {m_addr, m_wdata}, {8'h01, 8'h31});
    #1 rst = 1;
    #1;
    chk("rm_sel",   m_sel, 0);
    chk("rm_busy",  busy, 0);
    chk("rm_rdy",   cmd_ready, 0);
    tick(); tick();
    rst = 0;
    repeat (4) tick();
    chk("rm_n",     log_q.size(), 2);
    begin
      int tie = 0;
      foreach (log_q[i]) if (log_q[i][15:8] == 8'h03) tie++;
      chk("rm_tie", tie, 0);
    end
    chk("rm_idle",  busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
